// File: rtl/comma_word_aligner_if.sv
// Symbol path between the deserializer bit stream, the word aligner and the 10b/8b decoder.
// master is the aligner side: it takes the serial bit and drives the aligned symbol outputs.
interface comma_word_aligner_if;
    logic       is;
    logic [9:0] op;
    logic       valid;
    logic       is_comma;
    logic       locked;

    modport master (input is, output op, valid, is_comma, locked);
    modport slave  (output is, input op, valid, is_comma, locked);
endinterface

// File: rtl/comma_word_aligner.sv
// K28.5 comma hunter and 10-bit word aligner for the 8b/10b receive path.
// Serial bits enter LSB first; aligned symbols leave with a one-cycle valid strobe.
module comma_word_aligner #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned MIS_MAX  = 2
) (
    input  logic                        clock,
    input  logic                        reset_l,
    comma_word_aligner_if.master        bus
);
    // state  | meaning
    // HUNT   | no alignment, any comma position accepted
    // SYNC   | candidate phase, counting aligned commas toward lock
    // LOCKED | phase held, symbols delivered every 10 clocks
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;
    localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0] MIS_TGT   = 4'(MIS_MAX);

    state_t     state;
    logic [9:0] sr;
    logic [3:0] ph;
    logic [3:0] cc;
    logic [3:0] mc;
    logic       match;
    logic       boundary;
    logic [3:0] cc_inc;
    logic [3:0] mc_inc;

    assign match    = (sr == K28_5_NEG) || (sr == K28_5_POS);
    assign boundary = (ph == 4'd9);
    assign cc_inc   = (cc == 4'd15) ? cc : cc + 4'd1;
    assign mc_inc   = (mc == 4'd15) ? mc : mc + 4'd1;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state        <= HUNT;
            sr           <= '0;
            ph           <= '0;
            cc           <= '0;
            mc           <= '0;
            bus.op       <= '0;
            bus.valid    <= 1'b0;
            bus.is_comma <= 1'b0;
            bus.locked   <= 1'b0;
        end else begin
            sr        <= {bus.is, sr[9:1]};
            ph        <= boundary ? 4'd0 : ph + 4'd1;
            bus.valid <= 1'b0;

            // The symbol that completes lock is seen while still in SYNC, so it is not delivered.
            if (state == LOCKED && boundary) begin
                bus.valid    <= 1'b1;
                bus.op       <= sr;
                bus.is_comma <= match;
            end

            case (state)
                HUNT: begin
                    if (match) begin
                        ph <= 4'd0;
                        cc <= 4'd1;
                        if (LOCK_TGT <= 4'd1) begin
                            state      <= LOCKED;
                            mc         <= 4'd0;
                            bus.locked <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (match) begin
                        if (boundary) begin
                            cc <= cc_inc;
                            if (cc_inc >= LOCK_TGT) begin
                                state      <= LOCKED;
                                mc         <= 4'd0;
                                bus.locked <= 1'b1;
                            end
                        end else begin
                            ph <= 4'd0;
                            cc <= 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if (boundary) begin
                            mc <= 4'd0;
                        end else begin
                            // Isolated misaligned commas are tolerated without moving the phase.
                            mc <= mc_inc;
                            if (mc_inc >= MIS_TGT) begin
                                ph         <= 4'd0;
                                cc         <= 4'd1;
                                state      <= SYNC;
                                bus.locked <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state      <= HUNT;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end
endmodule
